// File: rtl/reg_seq_pkg.sv
// Shared types and default configuration for the register-read sequencer.
package reg_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_DWELL_W    = 8;
  localparam int DEF_DWELL_MAX  = 180;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_ADDR_FIRST = 0;
  localparam int DEF_ADDR_LAST  = 8;

endpackage

// File: rtl/seq_next_addr.sv
// Combinational next-address / last-address finder for the scan window.
// With ADDR_SKIP_EN defined, masked addresses are skipped and all-masked is flagged.
module seq_next_addr #(
  parameter int ADDR_W     = 4,
  parameter int ADDR_FIRST = 0,
  parameter int ADDR_LAST  = 8
) (
  input  logic [ADDR_W-1:0]      addr_i,
`ifdef ADDR_SKIP_EN
  input  logic [2**ADDR_W-1:0]   mask_i,
  output logic                   none_o,
`endif
  output logic [ADDR_W-1:0]      next_addr_o,
  output logic [ADDR_W-1:0]      first_addr_o,
  output logic                   is_last_o
);

`ifdef ADDR_SKIP_EN
  // Descending searches so the lowest qualifying address is the one left standing.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    first_addr_o = ADDR_W'(ADDR_FIRST);
    none_o       = 1'b1;
    for (int i = ADDR_LAST; i >= ADDR_FIRST; i--) begin
      if (!mask_i[i]) begin
        first_addr_o = ADDR_W'(i);
        none_o       = 1'b0;
      end
    end
    next_addr_o = first_addr_o;
    is_last_o   = 1'b1;
    for (int i = ADDR_LAST; i >= ADDR_FIRST; i--) begin
      if (!mask_i[i] && (i > int'(addr_i))) begin
        next_addr_o = ADDR_W'(i);
        is_last_o   = 1'b0;
      end
    end
  end
`else
  assign first_addr_o = ADDR_W'(ADDR_FIRST);
  assign is_last_o    = (addr_i == ADDR_W'(ADDR_LAST));
  assign next_addr_o  = is_last_o ? first_addr_o : addr_i + ADDR_W'(1);
`endif

endmodule

// File: rtl/reg_read_sequencer.sv
// Walks register addresses ADDR_FIRST..ADDR_LAST, dwelling DWELL_MAX+1 clocks on each,
// with start/done handshake, single-shot/continuous scan and stall. Optional macro: ADDR_SKIP_EN.
module reg_read_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DWELL_W    = DEF_DWELL_W,
  parameter int DWELL_MAX  = DEF_DWELL_MAX,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int ADDR_FIRST = DEF_ADDR_FIRST,
  parameter int ADDR_LAST  = DEF_ADDR_LAST
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 start,
  input  logic                 mode_cont,
  input  logic                 hold,
`ifdef ADDR_SKIP_EN
  input  logic [2**ADDR_W-1:0] skip_mask,
`endif
  output logic [DWELL_W-1:0]   dwell,
  output logic [ADDR_W-1:0]    addr,
  output logic                 addr_stb,
  output logic                 busy,
  output logic                 done,
  output logic                 wrap
);

  state_e              state_q, state_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                mode_q, mode_d;
  logic                stb_q, stb_d;
  logic                done_q, done_d;
  logic                wrap_q, wrap_d;

  logic [ADDR_W-1:0]   next_addr;
  logic [ADDR_W-1:0]   first_addr;
  logic                is_last;

`ifdef ADDR_SKIP_EN
  logic [2**ADDR_W-1:0] mask_q, mask_d;
  logic [2**ADDR_W-1:0] mask_sel;
  logic                 all_masked;

  // In IDLE the live mask decides the first address; during RUN the captured one does.
  assign mask_sel = (state_q == IDLE) ? skip_mask : mask_q;
`endif

  seq_next_addr #(
    .ADDR_W     (ADDR_W),
    .ADDR_FIRST (ADDR_FIRST),
    .ADDR_LAST  (ADDR_LAST)
  ) u_next_addr (
    .addr_i       (addr_q),
`ifdef ADDR_SKIP_EN
    .mask_i       (mask_sel),
    .none_o       (all_masked),
`endif
    .next_addr_o  (next_addr),
    .first_addr_o (first_addr),
    .is_last_o    (is_last)
  );

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
`ifdef ADDR_SKIP_EN
    mask_d  = mask_q;
`endif
    if (!en) begin
      state_d = IDLE;
      dwell_d = '0;
      addr_d  = ADDR_W'(ADDR_FIRST);
    end else begin
      unique case (state_q)
        IDLE: begin
          dwell_d = '0;
          addr_d  = ADDR_W'(ADDR_FIRST);
          if (start) begin
            mode_d = mode_cont;
`ifdef ADDR_SKIP_EN
            mask_d = skip_mask;
            if (all_masked) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              addr_d  = first_addr;
              stb_d   = 1'b1;
            end
`else
            state_d = RUN;
            addr_d  = first_addr;
            stb_d   = 1'b1;
`endif
          end
        end
        RUN: begin
          if (!hold) begin
            if (dwell_q != DWELL_W'(DWELL_MAX)) begin
              dwell_d = dwell_q + DWELL_W'(1);
            end else begin
              dwell_d = '0;
              if (!is_last) begin
                addr_d = next_addr;
                stb_d  = 1'b1;
              end else if (mode_q) begin
                addr_d = first_addr;
                stb_d  = 1'b1;
                wrap_d = 1'b1;
              end else begin
                state_d = IDLE;
                addr_d  = ADDR_W'(ADDR_FIRST);
                done_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dwell_q <= '0;
      addr_q  <= ADDR_W'(ADDR_FIRST);
      mode_q  <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef ADDR_SKIP_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
`ifdef ADDR_SKIP_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign dwell    = dwell_q;
  assign addr     = addr_q;
  assign addr_stb = stb_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_reg_read_sequencer.sv
// Directed self-checking bench for reg_read_sequencer at default parameters
// (address 0..8, 181-clock windows). Skip-mask vectors run when ADDR_SKIP_EN is defined.
module tb_reg_read_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, start, mode_cont, hold;
  logic [7:0] dwell;
  logic [3:0] addr;
  logic       addr_stb, busy, done, wrap;
`ifdef ADDR_SKIP_EN
  logic [15:0] skip_mask;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_stb, n_done, n_wrap, n_idle;

  always #5 clk = ~clk;

  reg_read_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .start     (start),
    .mode_cont (mode_cont),
    .hold      (hold),
`ifdef ADDR_SKIP_EN
    .skip_mask (skip_mask),
`endif
    .dwell     (dwell),
    .addr      (addr),
    .addr_stb  (addr_stb),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_scan(input logic cont);
    start     = 1'b1;
    mode_cont = cont;
    tick();
    cyc   = 1;
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_dwell"}, int'(dwell), 0);
    check({tag, "_addr"},  int'(addr), 0);
    check({tag, "_stb"},   int'(addr_stb), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_wrap"},  int'(wrap), 0);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; start = 1'b0; mode_cont = 1'b0; hold = 1'b0;
`ifdef ADDR_SKIP_EN
    skip_mask = '0;
`endif
    tick(); tick();
    check_idle("rst");
    reset_n = 1'b1;
    tick();

    // Single-shot scan; stray start and mode change mid-run must be ignored.
    start_scan(1'b0);
    check("t1_first_stb", int'(addr_stb), 1);
    check("t1_first_addr", int'(addr), 0);
    check("t1_first_busy", int'(busy), 1);
    n_stb = 1; n_done = 0; n_wrap = 0;
    while (cyc < 1640) begin
      tick();
      start     = (cyc == 100);
      mode_cont = (cyc >= 200);
      if (addr_stb) begin
        check("t1_stb_addr", int'(addr), (cyc - 1) / 181);
        check("t1_stb_phase", (cyc - 1) % 181, 0);
        n_stb++;
      end
      if (done) begin
        check("t1_done_cyc", cyc, 1630);
        n_done++;
      end
      if (wrap) n_wrap++;
      if (cyc == 1 + 181 * 3 + 50) begin
        check("t1_mid_dwell", int'(dwell), 50);
        check("t1_mid_addr", int'(addr), 3);
      end
      if (cyc == 1629) begin
        check("t1_last_busy", int'(busy), 1);
        check("t1_last_dwell", int'(dwell), 180);
        check("t1_last_addr", int'(addr), 8);
      end
      if (cyc == 1630) begin
        check("t1_end_busy", int'(busy), 0);
        check("t1_end_addr", int'(addr), 0);
        check("t1_end_dwell", int'(dwell), 0);
      end
    end
    check("t1_n_stb", n_stb, 9);
    check("t1_n_done", n_done, 1);
    check("t1_n_wrap", n_wrap, 0);

    // Continuous scan over two frames, then stop via en.
    start_scan(1'b1);
    n_done = 0; n_wrap = 0; n_idle = 0;
    while (cyc < 3265) begin
      tick();
      if (wrap) begin
        check("t2_wrap_cyc", cyc, (n_wrap == 0) ? 1630 : 3259);
        check("t2_wrap_addr", int'(addr), 0);
        check("t2_wrap_stb", int'(addr_stb), 1);
        n_wrap++;
      end
      if (done) n_done++;
      if (!busy) n_idle++;
    end
    check("t2_n_wrap", n_wrap, 2);
    check("t2_n_done", n_done, 0);
    check("t2_n_idle", n_idle, 0);
    en = 1'b0;
    tick();
    check_idle("t2_stop");
    en = 1'b1;
    tick();

    // Hold for 10 clocks at addr 3 dwell 50; next window arrives 10 clocks late.
    start_scan(1'b0);
    while (cyc < 1 + 181 * 3 + 50) tick();
    hold = 1'b1;
    repeat (10) tick();
    check("t3_hold_dwell", int'(dwell), 50);
    check("t3_hold_addr", int'(addr), 3);
    check("t3_hold_stb", int'(addr_stb), 0);
    hold = 1'b0;
    tick();
    check("t3_resume_dwell", int'(dwell), 51);
    while (!addr_stb && cyc < 800) tick();
    check("t3_stb4_cyc", cyc, 1 + 181 * 4 + 10);
    check("t3_stb4_addr", int'(addr), 4);

    // en low at addr 5 dwell 100 (with start also high) clears to IDLE without done.
    while (cyc < 1 + 181 * 5 + 100 + 10) tick();
    check("t4_pre_addr", int'(addr), 5);
    check("t4_pre_dwell", int'(dwell), 100);
    en    = 1'b0;
    start = 1'b1;
    tick();
    check_idle("t4_clear");
    en = 1'b1;
    start_scan(1'b0);
    check("t4_restart_stb", int'(addr_stb), 1);
    check("t4_restart_addr", int'(addr), 0);
    check("t4_restart_busy", int'(busy), 1);

    // Async reset mid-window takes effect without a clock edge.
    repeat (300) tick();
    check("t5_pre_addr", int'(addr), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("t5_async");
    #2;
    reset_n = 1'b1;
    tick();
    start_scan(1'b0);
    check("t5_restart_stb", int'(addr_stb), 1);
    repeat (181) tick();
    check("t5_second_stb", int'(addr_stb), 1);
    check("t5_second_addr", int'(addr), 1);
    en = 1'b0;
    tick();
    en = 1'b1;

`ifdef ADDR_SKIP_EN
    // Odd addresses masked: windows only at 0,2,4,6,8.
    skip_mask = 16'h00AA;
    start_scan(1'b0);
    n_stb = 0; n_done = 0;
    if (addr_stb) n_stb++;
    skip_mask = 16'hFFFF;
    while (cyc < 910) begin
      tick();
      if (addr_stb) begin
        check("t6_stb_addr", int'(addr), 2 * n_stb);
        check("t6_stb_cyc", cyc, 1 + 181 * n_stb);
        n_stb++;
      end
      if (done) begin
        check("t6_done_cyc", cyc, 5 * 181 + 1);
        n_done++;
      end
    end
    check("t6_n_stb", n_stb, 5);
    check("t6_n_done", n_done, 1);

    // All window addresses masked: no RUN, done one clock after start.
    skip_mask = 16'h01FF;
    start_scan(1'b1);
    check("t6_all_done", int'(done), 1);
    check("t6_all_busy", int'(busy), 0);
    check("t6_all_stb", int'(addr_stb), 0);
    tick();
    check("t6_all_done_clr", int'(done), 0);
    check("t6_all_busy2", int'(busy), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
